// File: rtl/mosbius_cfg_if.sv
// ----------------------------------------------------------------------------
// mosbius_cfg_if
//   Bundles the host-facing serial configuration signals of the MOSbius
//   switch-matrix controller.
//
//   Parameter:
//     CFG_W      switch-control width (NBUS*NPIN of the attached controller)
//
//   Signals:
//     enable     host -> ctrl  frame strobe (high = shifting, fall = commit)
//     dat_in     host -> ctrl  serial config data, MSB of the frame first
//     dat_out    ctrl -> host  shift-register MSB, for daisy-chain / echo
//     sw_ctrl    ctrl -> host  active switch controls, 1 = closed
//     cfg_valid  ctrl -> host  a frame has been applied since reset
//     frame_err  ctrl -> host  sticky: last frame was rejected
//     busy       ctrl -> host  break-before-make in progress
//
//   Modports: master (host side), slave (controller side).
// ----------------------------------------------------------------------------
interface mosbius_cfg_if #(
  parameter int CFG_W = 100
) ();
  logic             enable;
  logic             dat_in;
  logic             dat_out;
  logic [CFG_W-1:0] sw_ctrl;
  logic             cfg_valid;
  logic             frame_err;
  logic             busy;

  modport master (
    output enable, dat_in,
    input  dat_out, sw_ctrl, cfg_valid, frame_err, busy
  );

  modport slave (
    input  enable, dat_in,
    output dat_out, sw_ctrl, cfg_valid, frame_err, busy
  );
endinterface

// File: rtl/mosbius_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// mosbius_cfg_ctrl
//   Serial configuration controller for the MOSbius switch matrix
//   (NBUS analog buses x NPIN device terminals, one bit per switch).
//   The host shifts a frame in while enable is high; on the falling edge of
//   enable a length-checked frame is committed to the switch drivers through
//   a break-before-make sequence (all switches open for BBM_CYCLES cycles).
//
//   Parameters:
//     NBUS        number of analog buses
//     NPIN        number of device terminals (CFG_W = NBUS*NPIN >= 2)
//     BBM_CYCLES  cycles all switches are held open before applying (>= 1)
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous reset, active-high
//     bus   mosbius_cfg_if.slave: enable, dat_in in; dat_out, sw_ctrl,
//           cfg_valid, frame_err, busy out (all outputs are registered)
//
//   Build option:
//     MOSBIUS_CFG_PARITY_EN  when defined, each frame carries one extra
//                            trailing even-parity bit (frame = CFG_W+1 bits).
// ----------------------------------------------------------------------------
module mosbius_cfg_ctrl #(
  parameter int NBUS       = 5,
  parameter int NPIN       = 20,
  parameter int BBM_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  mosbius_cfg_if.slave  bus
);

  localparam int CFG_W = NBUS * NPIN;
`ifdef MOSBIUS_CFG_PARITY_EN
  localparam int FRAME_W = CFG_W + 1;
`else
  localparam int FRAME_W = CFG_W;
`endif
  localparam int CNT_W = $clog2(CFG_W + 3);
  localparam int BBM_W = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CFG_W_C   = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] FRAME_W_C = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);
  localparam logic [BBM_W-1:0] BBM_INIT  = BBM_W'(BBM_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_BREAK = 2'd2;

  logic [1:0]       r_state;
  logic [CFG_W-1:0] r_sreg;
  logic [CFG_W-1:0] r_shadow;
  logic [CFG_W-1:0] r_sw_ctrl;
  logic [CNT_W-1:0] r_cnt;
  logic [BBM_W-1:0] r_bbm_cnt;
  logic             r_enable_q;
  logic             r_cfg_valid;
  logic             r_frame_err;
  logic             w_frame_ok;

`ifdef MOSBIUS_CFG_PARITY_EN
  // Running XOR of every bit taken in the current frame, parity bit included.
  logic r_par;

  assign w_frame_ok = (r_cnt == FRAME_W_C) && !r_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (r_state == S_IDLE && bus.enable && !r_enable_q) begin
      r_par <= bus.dat_in;
    end else if (r_state == S_SHIFT && bus.enable) begin
      r_par <= r_par ^ bus.dat_in;
    end
  end
`else
  assign w_frame_ok = (r_cnt == FRAME_W_C);
`endif

  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // register samples the pre-edge values of the others regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sreg      <= '0;
      r_shadow    <= '0;
      r_sw_ctrl   <= '0;
      r_cnt       <= '0;
      r_bbm_cnt   <= '0;
      r_enable_q  <= 1'b0;
      r_cfg_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_enable_q <= bus.enable;

      case (r_state)
        S_IDLE: begin
          // Only a fresh rising edge starts a frame; enable held high from
          // a BREAK never yields a partial frame.
          if (bus.enable && !r_enable_q) begin
            r_sreg  <= {r_sreg[CFG_W-2:0], bus.dat_in};
            r_cnt   <= CNT_W'(1);
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (bus.enable) begin
            // Bits past CFG_W (parity / over-length) are counted, not shifted.
            if (r_cnt < CFG_W_C) begin
              r_sreg <= {r_sreg[CFG_W-2:0], bus.dat_in};
            end
            if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
            if (w_frame_ok) begin
              r_shadow  <= r_sreg;
              r_sw_ctrl <= '0;
              r_bbm_cnt <= BBM_INIT;
              r_state   <= S_BREAK;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
        end

        S_BREAK: begin
          // Full break-before-make even if shadow equals the current config.
          if (r_bbm_cnt == '0) begin
            r_sw_ctrl   <= r_shadow;
            r_cfg_valid <= 1'b1;
            r_frame_err <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_sw_ctrl <= '0;
            r_bbm_cnt <= r_bbm_cnt - 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dat_out   = r_sreg[CFG_W-1];
  assign bus.sw_ctrl   = r_sw_ctrl;
  assign bus.cfg_valid = r_cfg_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state == S_BREAK);

endmodule

// File: tb/tb_mosbius_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mosbius_cfg_ctrl
//   Self-checking bench for mosbius_cfg_ctrl with NBUS=2, NPIN=4 (CFG_W=8),
//   BBM_CYCLES=2. Directed scenarios plus randomized frames, all checked
//   against a frame-level reference model. Honors MOSBIUS_CFG_PARITY_EN.
// ----------------------------------------------------------------------------
module tb_mosbius_cfg_ctrl;
  localparam int CFG_W = 8;
  localparam int BBM   = 2;
`ifdef MOSBIUS_CFG_PARITY_EN
  localparam int FRAME_W = CFG_W + 1;
`else
  localparam int FRAME_W = CFG_W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  logic [7:0] m_sreg  = '0;
  logic [7:0] m_sw    = '0;
  logic       m_valid = 1'b0;
  logic       m_err   = 1'b0;

  mosbius_cfg_if #(.CFG_W(CFG_W)) bus ();

  mosbius_cfg_ctrl #(.NBUS(2), .NPIN(4), .BBM_CYCLES(BBM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sw_ctrl"},   32'(bus.sw_ctrl),   32'(m_sw));
    check({tag, ".cfg_valid"}, 32'(bus.cfg_valid), 32'(m_valid));
    check({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_err));
    check({tag, ".dat_out"},   32'(bus.dat_out),   32'(m_sreg[7]));
  endtask

  task automatic model_reset();
    m_sreg = '0; m_sw = '0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  // A well-formed frame carrying value v (parity appended when enabled).
  function automatic logic [15:0] good_bits(input logic [7:0] v);
`ifdef MOSBIUS_CFG_PARITY_EN
    return {7'd0, v, ^v};
`else
    return {8'd0, v};
`endif
  endfunction

  // Shift len bits MSB-first with enable high; checks dat_out per bit.
  // Returns the XOR of all bits driven.
  task automatic shift_bits(input logic [15:0] bits, input int len, output bit par);
    par = 1'b0;
    for (int i = 0; i < len; i++) begin
      logic b;
      b = bits[len-1-i];
      bus.enable = 1'b1;
      bus.dat_in = b;
      tick();
      if (i < CFG_W) m_sreg = {m_sreg[6:0], b};
      par ^= b;
      check("shift.dat_out", 32'(bus.dat_out), 32'(m_sreg[7]));
    end
  endtask

  // Full frame: shift, drop enable (edge E), follow break-before-make.
  // hold_en re-raises enable right after E and leaves it high.
  task automatic send(input logic [15:0] bits, input int len, input bit hold_en);
    bit par;
    bit accept;
    shift_bits(bits, len, par);
    bus.enable = 1'b0;
    bus.dat_in = 1'($urandom);
    tick();
`ifdef MOSBIUS_CFG_PARITY_EN
    accept = (len == FRAME_W) && (par == 1'b0);
`else
    accept = (len == FRAME_W);
`endif
    if (accept) begin
      bus.enable = hold_en;
      for (int k = 0; k < BBM; k++) begin
        if (k > 0) begin
          bus.dat_in = 1'($urandom);
          tick();
        end
        check("bbm.busy",    32'(bus.busy),    32'd1);
        check("bbm.sw_ctrl", 32'(bus.sw_ctrl), 32'd0);
      end
      tick();
      m_sw = m_sreg; m_valid = 1'b1; m_err = 1'b0;
      check("apply.busy", 32'(bus.busy), 32'd0);
      check_all("apply");
    end else begin
      m_err = 1'b1;
      check("reject.busy", 32'(bus.busy), 32'd0);
      check_all("reject");
    end
  endtask

  initial begin
    bit par;
    bus.enable = 1'b0;
    bus.dat_in = 1'b0;

    // 1: reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    check("reset.busy", 32'(bus.busy), 32'd0);
    check_all("reset");

    // 2: basic load with BBM timing
    send(good_bits(8'hA5), FRAME_W, 1'b0);
    check("a5.sw_ctrl", 32'(bus.sw_ctrl), 32'hA5);

    // 3: short and long frames rejected, config kept, then recovery
    send(good_bits(8'h3C), FRAME_W, 1'b0);
    send(good_bits(8'h3C) >> 1, FRAME_W - 1, 1'b0);
    check("short.sw_ctrl", 32'(bus.sw_ctrl), 32'h3C);
    send({good_bits(8'h12), 1'b1}, FRAME_W + 1, 1'b0);
    check("long.sw_ctrl", 32'(bus.sw_ctrl), 32'h3C);
    send(good_bits(8'hFF), FRAME_W, 1'b0);
    check("ff.frame_err", 32'(bus.frame_err), 32'd0);
    check("ff.sw_ctrl", 32'(bus.sw_ctrl), 32'hFF);

    // Identical config still runs full break-before-make
    send(good_bits(8'hFF), FRAME_W, 1'b0);

    // 4: enable re-asserted during BREAK and held: no frame starts
    send(good_bits(8'h5A), FRAME_W, 1'b1);
    for (int k = 0; k < 3; k++) begin
      bus.dat_in = 1'($urandom);
      tick();
    end
    check_all("held");
    bus.enable = 1'b0;
    tick(); tick();
    check_all("held.drop");
    send(good_bits(8'h81), FRAME_W, 1'b0);
    check("81.sw_ctrl", 32'(bus.sw_ctrl), 32'h81);

    // 5a: reset mid-frame (cnt=4)
    shift_bits(16'h000F, 4, par);
    rst = 1'b1; bus.enable = 1'b0;
    tick();
    rst = 1'b0;
    model_reset();
    check("rst_frame.busy", 32'(bus.busy), 32'd0);
    check_all("rst_frame");

    // 5b: reset mid-BREAK
    send(good_bits(8'hC3), FRAME_W, 1'b0);
    shift_bits(good_bits(8'h77), FRAME_W, par);
    bus.enable = 1'b0;
    tick();
    check("rst_bbm.pre_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("rst_bbm.busy", 32'(bus.busy), 32'd0);
    check_all("rst_bbm");

`ifdef MOSBIUS_CFG_PARITY_EN
    // 6: parity
    send({7'd0, 8'hA5, 1'b0}, FRAME_W, 1'b0);
    check("par_ok.sw_ctrl", 32'(bus.sw_ctrl), 32'hA5);
    send({7'd0, 8'h0F, 1'b1}, FRAME_W, 1'b0);
    check("par_bad.sw_ctrl", 32'(bus.sw_ctrl), 32'hA5);
    check("par_bad.frame_err", 32'(bus.frame_err), 32'd1);
    send({8'd0, 8'hA5}, CFG_W, 1'b0);
    check("par_short.frame_err", 32'(bus.frame_err), 32'd1);
`endif

    // Randomized frames against the model
    for (int it = 0; it < 30; it++) begin
      logic [7:0]  v;
      logic [15:0] bits;
      int          kind;
      v    = 8'($urandom);
      kind = int'($urandom_range(0, 5));
      bits = good_bits(v);
      case (kind)
        0: send(bits >> 1, FRAME_W - 1, 1'b0);
        1: send({bits[14:0], 1'($urandom)}, FRAME_W + 1, 1'b0);
        2: send(bits ^ 16'd1, FRAME_W, 1'b0);
        3: send(16'(1'($urandom)), 1, 1'b0);
        default: send(bits, FRAME_W, 1'b0);
      endcase
      repeat (int'($urandom_range(0, 2))) tick();
    end
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
